// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard sequencer bundle: hazard sources in, stall/bubble/flush controls and counters out.
// Pure wiring; the pipeline (master) drives hazard sources, the sequencer (slave) drives controls.
interface hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             ex_valid;
    logic             ex_is_load;
    logic [REG_W-1:0] ex_dst;
    logic             ex_redirect;
    logic             mem_req;
    logic             mem_data_ok;
    logic             if_pending;
    logic             if_data_ok;

    logic             stall_if;
    logic             stall_id;
    logic             stall_ex;
    logic             stall_mem;
    logic             bubble_ex;
    logic             bubble_wb;
    logic             flush_if_id;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_valid, ex_is_load, ex_dst, ex_redirect,
        output mem_req, mem_data_ok, if_pending, if_data_ok,
        input  stall_if, stall_id, stall_ex, stall_mem,
        input  bubble_ex, bubble_wb, flush_if_id, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_valid, ex_is_load, ex_dst, ex_redirect,
        input  mem_req, mem_data_ok, if_pending, if_data_ok,
        output stall_if, stall_id, stall_ex, stall_mem,
        output bubble_ex, bubble_wb, flush_if_id, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer: load-use stall, dmem freeze, redirect squash, stale-fetch discard, perf counters.
// Zero-cycle combinational controls from state+inputs; no backpressure of its own, it is the backpressure.
module hazard_ctrl #(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
);
    typedef enum logic [1:0] {RUN, DMEM_WAIT, IF_DISCARD} state_t;

    state_t           state_q, state_d;
    logic             pend_dmem_q, pend_dmem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic dmem_busy;
    logic lu_hit;
    logic rs1_hit;
    logic rs2_hit;
    logic dmem_frz;
    logic flush_inc;
    logic s_if, s_id, s_ex, s_mem, b_ex, b_wb, f_ifid;

    assign dmem_busy = hz.mem_req & ~hz.mem_data_ok;
    assign rs1_hit   = hz.id_use_rs1 & (hz.id_rs1 == hz.ex_dst);
    assign rs2_hit   = hz.id_use_rs2 & (hz.id_rs2 == hz.ex_dst);
    assign lu_hit    = hz.ex_valid & hz.ex_is_load & (hz.ex_dst != '0) &
                       hz.id_valid & (rs1_hit | rs2_hit);

    always_comb begin
        state_d     = state_q;
        pend_dmem_d = 1'b0;
        dmem_frz    = 1'b0;
        flush_inc   = 1'b0;
        s_if        = 1'b0;
        s_id        = 1'b0;
        s_ex        = 1'b0;
        s_mem       = 1'b0;
        b_ex        = 1'b0;
        b_wb        = 1'b0;
        f_ifid      = 1'b0;
        case (state_q)
            RUN: begin
                // Freeze outranks redirect and load-use; both re-present once unstalled.
                if (dmem_busy) begin
                    {s_if, s_id, s_ex, s_mem, b_wb} = 5'b11111;
                    state_d = DMEM_WAIT;
                end else if (hz.ex_redirect) begin
                    f_ifid    = 1'b1;
                    b_ex      = 1'b1;
                    flush_inc = 1'b1;
                    if (hz.if_pending & ~hz.if_data_ok) begin
                        state_d = IF_DISCARD;
                    end
                end else if (lu_hit) begin
                    s_if = 1'b1;
                    s_id = 1'b1;
                    b_ex = 1'b1;
                end
            end
            DMEM_WAIT: begin
                if (!hz.mem_data_ok) begin
                    {s_if, s_id, s_ex, s_mem, b_wb} = 5'b11111;
                end else begin
                    state_d = RUN;
                end
            end
            IF_DISCARD: begin
                // Fetch drop and dmem completion are independent handshakes.
                dmem_frz = dmem_busy | (pend_dmem_q & ~hz.mem_data_ok);
                s_if     = 1'b1;
                f_ifid   = 1'b1;
                if (dmem_frz) begin
                    {s_id, s_ex, s_mem, b_wb} = 4'b1111;
                end
                flush_inc = hz.ex_redirect & ~dmem_frz;
                if (hz.if_data_ok) begin
                    state_d = dmem_frz ? DMEM_WAIT : RUN;
                end else begin
                    pend_dmem_d = dmem_frz;
                end
            end
            default: state_d = RUN;
        endcase

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (s_if && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush_inc && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end

        // Reset must silence the pipeline controls immediately, not at the next edge.
        if (reset) begin
            {s_if, s_id, s_ex, s_mem, b_ex, b_wb, f_ifid} = 7'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            pend_dmem_q <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_dmem_q <= pend_dmem_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall_if    = s_if;
    assign hz.stall_id    = s_id;
    assign hz.stall_ex    = s_ex;
    assign hz.stall_mem   = s_mem;
    assign hz.bubble_ex   = b_ex;
    assign hz.bubble_wb   = b_wb;
    assign hz.flush_if_id = f_ifid;
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed + random bench for hazard_ctrl against a rule-level reference model (4-bit counters).
module tb_hazard_ctrl;
    localparam int REG_W = 5;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    // Reference model: "waiting on dmem", "discarding a fetch", "dmem outstanding while discarding"
    bit m_wait, m_disc, m_pend;
    int m_sc, m_fc;
    bit mem_out;

    hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hz ();

    hazard_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle();
        hz.id_valid = 0; hz.id_rs1 = 0; hz.id_rs2 = 0; hz.id_use_rs1 = 0; hz.id_use_rs2 = 0;
        hz.ex_valid = 0; hz.ex_is_load = 0; hz.ex_dst = 0; hz.ex_redirect = 0;
        hz.mem_req = 0; hz.mem_data_ok = 0; hz.if_pending = 0; hz.if_data_ok = 0;
    endtask

    task automatic set_lu(input int dst, input int rs1);
        hz.ex_valid = 1; hz.ex_is_load = 1; hz.ex_dst = dst[REG_W-1:0];
        hz.id_valid = 1; hz.id_rs1 = rs1[REG_W-1:0]; hz.id_use_rs1 = 1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".stall_if"}, 32'(hz.stall_if), 0);
        chk({tag, ".stall_id"}, 32'(hz.stall_id), 0);
        chk({tag, ".stall_ex"}, 32'(hz.stall_ex), 0);
        chk({tag, ".stall_mem"}, 32'(hz.stall_mem), 0);
        chk({tag, ".bubble_ex"}, 32'(hz.bubble_ex), 0);
        chk({tag, ".bubble_wb"}, 32'(hz.bubble_wb), 0);
        chk({tag, ".flush_if_id"}, 32'(hz.flush_if_id), 0);
    endtask

    // Reset asserted mid-cycle: outputs must drop at once, counters clear.
    task automatic do_reset(input string tag);
        reset = 1;
        #1;
        chk_quiet(tag);
        chk({tag, ".stall_cnt"}, 32'(hz.stall_cnt), 0);
        chk({tag, ".flush_cnt"}, 32'(hz.flush_cnt), 0);
        @(posedge clk);
        #3;
        idle();
        reset = 0;
        m_wait = 0; m_disc = 0; m_pend = 0; m_sc = 0; m_fc = 0; mem_out = 0;
        #1;
    endtask

    // One clock: compare against model outputs for the current inputs, then advance.
    task automatic step(input string tag);
        bit busy, lu, dfrz, redir, ok;
        bit e_sif, e_sid, e_sex, e_smem, e_bex, e_bwb, e_fl;
        bit n_wait, n_disc, n_pend;
        #2;
        ok    = hz.mem_data_ok;
        redir = hz.ex_redirect;
        busy  = hz.mem_req && !ok;
        lu    = hz.ex_valid && hz.ex_is_load && hz.ex_dst != 0 && hz.id_valid &&
                ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_dst) || (hz.id_use_rs2 && hz.id_rs2 == hz.ex_dst));
        {e_sif, e_sid, e_sex, e_smem, e_bex, e_bwb, e_fl} = '0;
        n_wait = m_wait; n_disc = m_disc; n_pend = 0;
        chk({tag, ".stall_cnt"}, 32'(hz.stall_cnt), 32'(m_sc));
        chk({tag, ".flush_cnt"}, 32'(hz.flush_cnt), 32'(m_fc));
        if (m_wait) begin
            if (!ok) {e_sif, e_sid, e_sex, e_smem, e_bwb} = '1;
            else n_wait = 0;
        end else if (m_disc) begin
            dfrz  = busy || (m_pend && !ok);
            e_sif = 1;
            e_fl  = 1;
            if (dfrz) {e_sid, e_sex, e_smem, e_bwb} = '1;
            if (redir && !dfrz) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
            if (hz.if_data_ok) begin
                n_disc = 0;
                n_wait = dfrz;
            end else begin
                n_pend = dfrz;
            end
        end else if (busy) begin
            {e_sif, e_sid, e_sex, e_smem, e_bwb} = '1;
            n_wait = 1;
        end else if (redir) begin
            e_fl = 1; e_bex = 1;
            m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
            n_disc = hz.if_pending && !hz.if_data_ok;
        end else if (lu) begin
            e_sif = 1; e_sid = 1; e_bex = 1;
        end
        if (e_sif) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
        chk({tag, ".stall_if"}, 32'(hz.stall_if), 32'(e_sif));
        chk({tag, ".stall_id"}, 32'(hz.stall_id), 32'(e_sid));
        chk({tag, ".stall_ex"}, 32'(hz.stall_ex), 32'(e_sex));
        chk({tag, ".stall_mem"}, 32'(hz.stall_mem), 32'(e_smem));
        chk({tag, ".bubble_ex"}, 32'(hz.bubble_ex), 32'(e_bex));
        chk({tag, ".bubble_wb"}, 32'(hz.bubble_wb), 32'(e_bwb));
        chk({tag, ".flush_if_id"}, 32'(hz.flush_if_id), 32'(e_fl));
        mem_out = hz.mem_req && !ok;
        @(posedge clk);
        #1;
        m_wait = n_wait; m_disc = n_disc; m_pend = n_pend;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        idle();
        reset = 0;
        #7;
        do_reset("reset");

        // Load-use, dst=5 then dst=0
        set_lu(5, 5);
        step("lu_hit");
        chk("lu_hit.stall_cnt_after", 32'(hz.stall_cnt), 1);
        idle();
        step("lu_clear");
        set_lu(0, 0);
        step("lu_dst0");
        idle();

        // Dmem wait: 3 busy cycles then response
        do_reset("reset_dmem");
        hz.mem_req = 1;
        step("dmem_c0");
        step("dmem_c1");
        step("dmem_c2");
        hz.mem_data_ok = 1;
        step("dmem_ok");
        idle();
        chk("dmem.stall_cnt", 32'(hz.stall_cnt), 3);
        step("dmem_after");

        // Redirect with fetch in flight; response arrives two cycles later
        do_reset("reset_redir");
        hz.ex_redirect = 1; hz.if_pending = 1;
        step("redir_c0");
        hz.ex_redirect = 0;
        step("redir_c1");
        hz.if_data_ok = 1;
        step("redir_drop");
        idle();
        step("redir_run");
        chk("redir.flush_cnt", 32'(hz.flush_cnt), 1);
        chk("redir.stall_cnt", 32'(hz.stall_cnt), 2);

        // Simultaneous dmem_busy + redirect + load-use
        do_reset("reset_simul");
        set_lu(7, 7);
        hz.mem_req = 1; hz.ex_redirect = 1; hz.if_pending = 0;
        step("simul_frz");
        hz.mem_data_ok = 1;
        step("simul_ok");
        hz.mem_req = 0; hz.mem_data_ok = 0;
        step("simul_redir");
        idle();
        chk("simul.flush_cnt", 32'(hz.flush_cnt), 1);
        step("simul_idle");

        // Async reset between edges while in DMEM_WAIT
        hz.mem_req = 1;
        step("arst_busy");
        step("arst_wait");
        do_reset("arst_mid_wait");
        step("arst_run");

        // Saturation of stall_cnt at 15
        hz.mem_req = 1;
        for (int i = 0; i < 20; i++) step("sat");
        chk("sat.stall_cnt", 32'(hz.stall_cnt), 15);
        hz.mem_data_ok = 1;
        step("sat_ok");
        idle();

        // Randomised legal traffic against the model
        do_reset("reset_rand");
        for (int i = 0; i < 600; i++) begin
            hz.id_valid    = ($urandom % 4) != 0;
            hz.id_rs1      = REG_W'($urandom % 4);
            hz.id_rs2      = REG_W'($urandom % 4);
            hz.id_use_rs1  = $urandom % 2;
            hz.id_use_rs2  = $urandom % 2;
            hz.ex_valid    = ($urandom % 4) != 0;
            hz.ex_is_load  = $urandom % 2;
            hz.ex_dst      = REG_W'($urandom % 4);
            hz.ex_redirect = ($urandom % 6) == 0;
            hz.if_pending  = $urandom % 2;
            hz.if_data_ok  = ($urandom % 5) < 2;
            if (mem_out) begin
                hz.mem_req     = 1;
                hz.mem_data_ok = ($urandom % 3) == 0;
            end else begin
                hz.mem_req     = ($urandom % 5) == 0;
                hz.mem_data_ok = hz.mem_req && ($urandom % 2);
            end
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline. Sits beside the EX-stage operand bypass network.
- Detects load-use hazards that bypassing cannot cover, and freezes the pipeline while a data-memory access is outstanding.
- Squashes wrong-path instructions on EX-stage redirects, and discards a stale in-flight fetch response after a redirect.
- Keeps saturating stall/flush performance counters.

Parameters:
CNT_W, 32, width of each performance counter
REG_W, 5, architectural register index width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
id_valid  in  1  ID stage holds a valid instruction
id_rs1  in  REG_W  ID source register 1
id_rs2  in  REG_W  ID source register 2
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_valid  in  1  EX stage holds a valid instruction
ex_is_load  in  1  EX instruction is a load
ex_dst  in  REG_W  EX destination register
ex_redirect  in  1  EX resolved a taken branch/jump mispredict
mem_req  in  1  MEM stage has a data-memory request this cycle
mem_data_ok  in  1  data-memory response valid
if_pending  in  1  instruction fetch request in flight
if_data_ok  in  1  instruction fetch response valid
stall_if  out  1  hold PC and IF/ID register
stall_id  out  1  hold ID/EX register contents
stall_ex  out  1  hold EX/MEM register
stall_mem  out  1  hold MEM stage
bubble_ex  out  1  load NOP into ID/EX register
bubble_wb  out  1  load NOP into MEM/WB register
flush_if_id  out  1  invalidate IF/ID register
stall_cnt  out  CNT_W  cycles with stall_if=1, saturating
flush_cnt  out  CNT_W  redirect events, saturating

Behaviour:
- Clock and reset: one clock `clk`. `reset` is asynchronous and active-high.
- Reset values:
  - state = RUN
  - all control outputs 0
  - counters 0
  - reset mid-wait returns to RUN immediately with no residual stall.
- States: RUN, DMEM_WAIT, IF_DISCARD.
- Hazard definitions:
  - dmem_busy = mem_req & ~mem_data_ok.
  - lu_hit = ex_valid & ex_is_load & ex_dst!=0 & id_valid & ((id_use_rs1 & id_rs1==ex_dst) | (id_use_rs2 & id_rs2==ex_dst)).
- Control outputs are combinational from current state and inputs. Priority per cycle: dmem_busy > ex_redirect > lu_hit.
- RUN:
  - dmem_busy:
    - stall_if=stall_id=stall_ex=stall_mem=1, bubble_wb=1.
    - Next state DMEM_WAIT.
    - ex_redirect and lu_hit are ignored this cycle; they re-present when unstalled.
  - Else ex_redirect:
    - flush_if_id=1, bubble_ex=1.
    - flush_cnt+1.
    - If if_pending & ~if_data_ok, next state IF_DISCARD; else stay RUN.
  - Else lu_hit:
    - stall_if=stall_id=1, bubble_ex=1 for exactly one cycle.
    - Next cycle the load is in MEM and bypass resolves the hazard.
- DMEM_WAIT:
  - Same freeze outputs as dmem_busy while ~mem_data_ok.
  - On mem_data_ok:
    - All stalls released, bubble_wb=0.
    - Next state RUN.
    - ex_redirect and lu_hit are NOT acted on this cycle; they are evaluated the following cycle in RUN.
  - mem_req deasserting without mem_data_ok is illegal and not checked.
- IF_DISCARD:
  - stall_if=1 and flush_if_id=1 every cycle.
  - On if_data_ok: response is dropped (flush_if_id=1 that cycle). Next state RUN, and the PC fetches the redirect target the next cycle.
  - dmem_busy in IF_DISCARD: also assert stall_id/ex/mem and bubble_wb while remaining in IF_DISCARD. DMEM completion then takes priority over the return to RUN only in the sense that both handshakes must complete; track them independently with a pending_dmem flag.
  - A second ex_redirect in IF_DISCARD counts in flush_cnt; state unchanged.
- Counters:
  - stall_cnt +1 on every cycle stall_if=1.
  - flush_cnt +1 per accepted redirect.
  - Both saturate at all-ones.
- Latency: zero-cycle combinational response to hazards; state updates on the rising clk edge.

Test Plan:
- Load-use: ex load dst=5, id rs1=5 use_rs1=1 -> stall_if=stall_id=bubble_ex=1 for 1 cycle. Same with dst=0 -> no stall.
- Dmem wait: mem_req=1, mem_data_ok low for 3 cycles then high -> all four stalls plus bubble_wb high for 3 cycles, released the cycle mem_data_ok=1. stall_cnt=3.
- Redirect with fetch in flight: ex_redirect=1, if_pending=1, if_data_ok arrives 2 cycles later -> flush_if_id high 3 cycles, response dropped, flush_cnt=1, state back to RUN.
- Simultaneous: dmem_busy, ex_redirect and lu_hit in the same cycle -> only the freeze is applied. The redirect is taken the cycle after DMEM_WAIT exits, giving flush_cnt=1.
- Async reset asserted mid-DMEM_WAIT, between clock edges -> all outputs 0 immediately. After release, state=RUN and counters=0.
- Saturation: preload stall_cnt to all-ones via a long stall (CNT_W=4, 20 stall cycles) -> stall_cnt holds 15.
